// File: rtl/tile_rng_pkg.sv
// tile_rng_pkg: shared FSM states, LFSR tap masks and default seed for the lane generator
package tile_rng_pkg;
  typedef enum logic {DRAW, HOLD} state_e;
  localparam logic [31:0] SEED_ONES = '1;
  // Bit t-1 is set for every tap t; unsupported widths give an empty mask.
  function automatic logic [31:0] tap_mask(input int width);
    return width == 5  ? 32'h0000_0014 :
           width == 8  ? 32'h0000_00B8 :
           width == 16 ? 32'h0000_D008 :
           width == 32 ? 32'h8020_0003 : 32'h0;
  endfunction
endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: free-running Fibonacci LFSR with seed load and zero-seed substitution
module lfsr_core
  import tile_rng_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] q
);
  localparam logic [WIDTH-1:0] MASK = WIDTH'(tap_mask(WIDTH));
  localparam logic [WIDTH-1:0] ONES = WIDTH'(SEED_ONES);
  logic [WIDTH-1:0] q_d;
  // A zero seed would lock the register, so it is replaced by all-ones.
  always_comb q_d = load ? (seed == '0 ? ONES : seed) : {q[WIDTH-2:0], ^(q & MASK)};
  // State register, all-ones out of reset.
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= ONES;
    else     q <= q_d;
endmodule

// File: rtl/tile_lane_rng.sv
// tile_lane_rng: LFSR-driven lane picker with range rejection and valid/ready output
// Optional repeat limiting is enabled by defining TILE_RNG_REPEAT_LIMIT_EN.
module tile_lane_rng
  import tile_rng_pkg::*;
#(
  parameter  int WIDTH      = 16,
  parameter  int LANES      = 4,
  parameter  int MAX_REPEAT = 2,
  localparam int LW         = $clog2(LANES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             lane_ready,
  output logic             lane_valid,
  output logic [LW-1:0]    lane,
  output logic [WIDTH-1:0] lfsr_q
);
  if (!(WIDTH == 5 || WIDTH == 8 || WIDTH == 16 || WIDTH == 32)) begin : g_bad_width
    $error("tile_lane_rng: WIDTH must be 5, 8, 16 or 32");
  end
  if (LANES < 2 || LANES > 16) begin : g_bad_lanes
    $error("tile_lane_rng: LANES must be 2..16");
  end
  if (MAX_REPEAT < 1 || MAX_REPEAT > 15) begin : g_bad_repeat
    $error("tile_lane_rng: MAX_REPEAT must be 1..15");
  end

  state_e        state_q;
  logic [LW-1:0] c;
  logic          ok;
  logic          hs;

  lfsr_core #(.WIDTH(WIDTH)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (seed_load),
    .seed (seed),
    .q    (lfsr_q)
  );

  assign c  = lfsr_q[LW-1:0];
  assign hs = lane_valid && lane_ready;

`ifdef TILE_RNG_REPEAT_LIMIT_EN
  logic [LW-1:0] last_q;
  logic [3:0]    run_q;
  // Candidate must be in range and must not extend a run already at the limit.
  always_comb ok = 32'(c) < LANES && !(c == last_q && run_q == 4'(MAX_REPEAT));
  // Track the most recently delivered lane and how many times in a row it went out.
  always_ff @(posedge clk or posedge rst)
    if (rst || seed_load) begin
      last_q <= '0;
      run_q  <= '0;
    end else if (hs) begin
      if (lane == last_q) run_q <= run_q == 4'd15 ? run_q : run_q + 4'd1;
      else begin
        last_q <= lane;
        run_q  <= 4'd1;
      end
    end
`else
  // Only out-of-range candidates are rejected.
  always_comb ok = 32'(c) < LANES;
`endif

  // Draw FSM: latch an acceptable candidate, then hold it until the spawner takes it.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= DRAW;
      lane       <= '0;
      lane_valid <= 1'b0;
    end else if (seed_load) begin
      state_q    <= DRAW;
      lane_valid <= 1'b0;
    end else if (state_q == DRAW) begin
      if (ok) begin
        lane       <= c;
        lane_valid <= 1'b1;
        state_q    <= HOLD;
      end
    end else if (hs) begin
      lane_valid <= 1'b0;
      state_q    <= DRAW;
    end
endmodule

// File: doc/tile_lane_rng.md
# tile_lane_rng

Parametrised pseudo-random lane generator for the tile spawner. A maximal-length Fibonacci LFSR of configurable width runs freely every clock, and a small draw FSM turns its low bits into a lane index in `0..LANES-1`. Indices that are out of range are rejected, and so are indices that would exceed the repeat limit. Accepted lanes go to the spawner over a valid/ready handshake. The block also supports runtime reseeding and exposes the raw LFSR state for debug.

## Interface
- `WIDTH`, 16: LFSR width. Legal values are 5, 8, 16, 32; any other value is an elaboration error.
- `LANES`, 4: number of lanes, 2..16.
- `MAX_REPEAT`, 2: maximum number of consecutive identical lanes, 1..15. Used only with the macro.
- `LW`, derived: `$clog2(LANES)`.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `seed_load  in  1`: synchronous reseed strobe.
- `seed  in  WIDTH`: seed value, sampled when `seed_load=1`.
- `lane_ready  in  1`: spawner accepts the lane.
- `lane_valid  out  1`: `lane` holds a fresh draw.
- `lane  out  LW`: drawn lane index.
- `lfsr_q  out  WIDTH`: current LFSR state.

## Operation
- **LFSR stepping**
  - Feedback `fb` is the XOR of `lfsr_q[t-1]` over all taps `t`.
  - Next state is `{lfsr_q[WIDTH-2:0], fb}`.
  - The LFSR steps every cycle except a `seed_load` cycle.
- **Tap sets**
  - WIDTH 5: taps {5,3}.
  - WIDTH 8: taps {8,6,5,4}.
  - WIDTH 16: taps {16,15,13,4}.
  - WIDTH 32: taps {32,22,2,1}.
- **Period**: `2^WIDTH-1`. The all-zero state is unreachable.
- **Candidate**: `c = lfsr_q[LW-1:0]`.
  - Rejected if `c >= LANES`.
  - With the macro, also rejected if `c == last_q` and `run_q == MAX_REPEAT`.
- **FSM, state DRAW**
  - If `c` is acceptable: `lane <= c`, `lane_valid <= 1`, go to HOLD.
  - Otherwise stay in DRAW. The next cycle retries with the stepped LFSR.
- **FSM, state HOLD**
  - `lane` and `lane_valid` are held stable; the LFSR keeps stepping.
  - On `lane_valid && lane_ready`: `lane_valid <= 0`, return to DRAW.
  - With the macro, the same handshake also updates the run tracking:
    - If `lane == last_q`, `run_q` increments, saturating at 15.
    - Otherwise `last_q <= lane` and `run_q <= 1`.
- **Reseed**: `seed_load` has top priority over every other action.
  - `lfsr_q <= (seed == 0) ? all-ones : seed`.
  - `lane_valid <= 0`, state goes to DRAW, `run_q <= 0`, `last_q <= 0`.
  - A lane pending in HOLD is discarded, even if `lane_ready` is high in the same cycle.
- **Reset** (asynchronous, `rst=1`):
  - `lfsr_q` = all-ones, `lane` = 0, `lane_valid` = 0.
  - State = DRAW, `last_q` = 0, `run_q` = 0.

## Timing
- Draw latency: `lane_valid` rises on the first edge at which a DRAW-state candidate is acceptable. The minimum is 1 cycle after entering DRAW.
- Sustained throughput with `lane_ready` tied high: one lane per 2 cycles (DRAW, then HOLD).
- Rejection streaks have no fixed bound. Termination is guaranteed within one LFSR period.
- `lane_ready` while `lane_valid=0` is ignored.
- `lane` is registered and `lane_valid` is registered. Neither output has a combinational path from any input.
- After `rst` deasserts, the first rising edge evaluates the candidate from the all-ones state.

## Configuration
- **`TILE_RNG_REPEAT_LIMIT_EN` defined**:
  - `last_q` and `run_q` registers exist.
  - The repeat rejection is active: no more than `MAX_REPEAT` identical consecutive lanes are accepted.
- **Undefined**:
  - The registers and the repeat check are removed.
  - Only range rejection applies.
  - `MAX_REPEAT` is ignored.

## Structure
- Shared package `tile_rng_pkg` holds:
  - The DRAW/HOLD state enum.
  - The tap-mask function `tap_mask(width)`, returning a WIDTH-bit mask per legal width.
  - The all-ones default-seed constant.
- One sub-module, `lfsr_core`, contains the LFSR register, stepping, seed load and zero-seed substitution. Its ports are `clk`, `rst`, `load`, `seed`, `q`.
- The draw FSM and the run tracking live in `tile_lane_rng`.

## Test plan
- **Reset sequence**: WIDTH=5, LANES=4, macro off, `lane_ready=0`.
  - `lfsr_q` steps 1F, 1E, 1C, 18, 11.
  - `lane=3`, `lane_valid=1` after the first edge; both stay stable while `lane_ready=0`.
- **Period**: WIDTH=5, free-running → `lfsr_q` returns to 1F after exactly 31 steps, with no repeated state in between. WIDTH=8 → period is 255.
- **Range rejection**: LANES=3, `lane_ready=1`, 2000 handshakes.
  - `lane` is never 3.
  - All of 0, 1, 2 occur.
  - `lane_valid` never rises in a cycle whose DRAW candidate was 3.
- **Repeat limit**: macro on, MAX_REPEAT=1, LANES=4, 2000 handshakes → no two consecutive accepted lanes are equal. With MAX_REPEAT=2, no three consecutive equal lanes occur.
- **Zero-seed reseed**: `seed_load=1` with `seed=0` → `lfsr_q=` all-ones on the next edge. `seed=0x0005` (WIDTH=16) → `lfsr_q=0x0005`.
- **Reseed during HOLD**: `seed_load=1` and `lane_ready=1` in the same cycle while in HOLD.
  - `lane_valid` drops to 0, the handshake is not counted and `run_q` = 0.
  - A new draw follows from the seeded state.
